// File: rtl/ab.sv
// rtl/ab.sv - clocked five-input majority voter with mismatch reporting.
// Optional per-channel fault counting and masking is enabled with AB_FAULT_MASK_EN.
module ab #(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] X,
  input  logic       clr_faults,
  output logic       Z,
  output logic [4:0] mismatch,
  output logic [4:0] masked,
  output logic       no_majority
);

  function automatic logic [2:0] pop5(input logic [4:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 5; i++) s = s + 3'(v[i]);
    return s;
  endfunction

`ifdef AB_FAULT_MASK_EN

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

  logic [4:0]       active;
  logic [3:0]       n_twice_cmp;
  logic [3:0]       ones_twice;
  logic             tie;
  logic             z_nxt;
  logic [4:0]       mis_nxt;
  logic [4:0]       mask_nxt;
  logic [CNT_W-1:0] cnt [5];
  logic [CNT_W-1:0] cnt_nxt [5];

  always_comb begin
    active      = ~masked;
    n_twice_cmp = {1'b0, pop5(active)};
    ones_twice  = {pop5(X & active), 1'b0};
    tie         = (ones_twice == n_twice_cmp);
    z_nxt       = tie ? Z : (ones_twice > n_twice_cmp);
    mis_nxt     = tie ? 5'b0 : (active & (X ^ {5{z_nxt}}));
  end

  // Counters only move on a decided vote; masked channels and ties freeze them.
  always_comb begin
    mask_nxt = masked;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt[i];
      if (clr_faults) begin
        cnt_nxt[i]  = '0;
        mask_nxt[i] = 1'b0;
      end else if (mis_nxt[i]) begin
        if (cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + 1'b1;
        if (cnt_nxt[i] == THRESH) mask_nxt[i] = 1'b1;
      end else if (active[i] && !tie) begin
        cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z           <= 1'b0;
      mismatch    <= '0;
      masked      <= '0;
      no_majority <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      Z           <= z_nxt;
      mismatch    <= mis_nxt;
      masked      <= mask_nxt;
      no_majority <= tie;
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`else

  localparam int unused_params = FAULT_THRESH + CNT_W;

  logic maj;
  logic unused_clr;

  assign unused_clr  = clr_faults;
  assign maj         = (pop5(X) >= 3'd3);
  assign masked      = '0;
  assign no_majority = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Z        <= 1'b0;
      mismatch <= '0;
    end else begin
      Z        <= maj;
      mismatch <= X ^ {5{maj}};
    end
  end

`endif

endmodule

// File: tb/tb_ab.sv
// tb/tb_ab.sv - directed self-checking bench for the ab majority voter.
// Expected values follow AB_FAULT_MASK_EN when it is defined.
module tb_ab;

  logic       clk;
  logic       rst;
  logic [4:0] X;
  logic       clr_faults;
  logic       Z;
  logic [4:0] mismatch;
  logic [4:0] masked;
  logic       no_majority;

  int n_tests;
  int n_fail;

  ab #(.FAULT_THRESH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .X          (X),
    .clr_faults (clr_faults),
    .Z          (Z),
    .mismatch   (mismatch),
    .masked     (masked),
    .no_majority(no_majority)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [4:0] x, input logic clr);
    X          = x;
    clr_faults = clr;
    @(posedge clk);
    #1;
    clr_faults = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic z, input logic [4:0] mm,
                            input logic [4:0] mk, input logic nm);
    check({tag, ".Z"}, {7'b0, Z}, {7'b0, z});
    check({tag, ".mismatch"}, {3'b0, mismatch}, {3'b0, mm});
    check({tag, ".masked"}, {3'b0, masked}, {3'b0, mk});
    check({tag, ".no_majority"}, {7'b0, no_majority}, {7'b0, nm});
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    X          = 5'b0;
    clr_faults = 1'b0;
    #1 rst = 1'b1;
    #2;
    expect_out("reset", 1'b0, 5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step(5'd0, 1'b0);  expect_out("x0", 1'b0, 5'b00000, 5'b00000, 1'b0);
    step(5'd1, 1'b0);  expect_out("x1", 1'b0, 5'b00001, 5'b00000, 1'b0);
    step(5'd4, 1'b0);  expect_out("x4", 1'b0, 5'b00100, 5'b00000, 1'b0);
    step(5'd18, 1'b0); expect_out("x18", 1'b0, 5'b10010, 5'b00000, 1'b0);
    step(5'd7, 1'b0);  expect_out("x7", 1'b1, 5'b11000, 5'b00000, 1'b0);
    step(5'd31, 1'b0); expect_out("x31", 1'b1, 5'b00000, 5'b00000, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step(5'd1, 1'b0);
      expect_out("hold1", 1'b0, 5'b00001, 5'b00000, 1'b0);
    end

`ifdef AB_FAULT_MASK_EN
    step(5'd1, 1'b0);          expect_out("mask_set", 1'b0, 5'b00001, 5'b00001, 1'b0);
    step(5'b11110, 1'b0);      expect_out("m_4of4", 1'b1, 5'b00000, 5'b00001, 1'b0);
    step(5'b00011, 1'b0);      expect_out("m_1of4", 1'b0, 5'b00010, 5'b00001, 1'b0);
    step(5'b00111, 1'b0);      expect_out("m_tie", 1'b0, 5'b00000, 5'b00001, 1'b1);
    step(5'b00111, 1'b1);      expect_out("clr", 1'b0, 5'b00000, 5'b00000, 1'b1);
    step(5'b00111, 1'b0);      expect_out("post_clr", 1'b1, 5'b11000, 5'b00000, 1'b0);
    for (int i = 0; i < 4; i++) step(5'd1, 1'b0);
    check("remask", {3'b0, masked}, 8'h01);
    step(5'b11110, 1'b0);      expect_out("pre_rst", 1'b1, 5'b00000, 5'b00001, 1'b0);
`else
    step(5'd1, 1'b0);          expect_out("mask_set", 1'b0, 5'b00001, 5'b00000, 1'b0);
    step(5'b11110, 1'b0);      expect_out("m_4of4", 1'b1, 5'b00001, 5'b00000, 1'b0);
    step(5'b00011, 1'b0);      expect_out("m_1of4", 1'b0, 5'b00011, 5'b00000, 1'b0);
    step(5'b00111, 1'b0);      expect_out("m_tie", 1'b1, 5'b11000, 5'b00000, 1'b0);
    step(5'b00111, 1'b1);      expect_out("clr", 1'b1, 5'b11000, 5'b00000, 1'b0);
    step(5'b00111, 1'b0);      expect_out("post_clr", 1'b1, 5'b11000, 5'b00000, 1'b0);
    step(5'b11110, 1'b0);      expect_out("pre_rst", 1'b1, 5'b00001, 5'b00000, 1'b0);
`endif

    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 5'b00000, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(5'b11100, 1'b0);      expect_out("after_rst", 1'b1, 5'b00011, 5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
